// File: rtl/bus_router_pkg.sv
// Shared types and helpers for the parametrised bus router.
// Holds the FSM state encoding, select-width helper and error read data.
package bus_router_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK_WAIT  = 2'd1,
    RESP_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // A single-slave build still needs one select bit so the address split is well formed.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Per-phase watchdog: cleared by load, counts while enabled, flags the final allowed cycle.
// A TIMEOUT_CYC of 0 removes the counter and never expires.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused;
    assign unused = ^{clk_i, rst_n_i, load, enable};
    assign expire = 1'b0;
  end else begin : g_on
    localparam int CNT_W = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= '0;
      end else if (enable && (cnt != LAST)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign expire = enable && (cnt == LAST);
  end

endmodule

// File: rtl/bus_router_n.sv
// Single-master to NUM_SLAVES request router with decode-error and per-phase timeout responses.
// Handshake: m_req is held until m_ack (and m_resp for reads) have pulsed, then dropped; s_req holds until the slave acks/responds.
module bus_router_n
  import bus_router_pkg::*;
#(
  parameter int          NUM_SLAVES  = 4,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF,
  localparam int         SEL_W       = sel_width(NUM_SLAVES)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         m_req,
  input  logic                         m_cmd,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_ack,
  output logic                         m_resp,
  output logic                         m_err,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_cmd,
  output logic [ADDR_W-SEL_W-1:0]      s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES-1:0]        s_resp,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output state_t                       dbg_state
);

  localparam logic [SEL_W:0]    NS_V     = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  state_t                  state, state_n;
  logic [SEL_W-1:0]        idx_q;
  logic [SEL_W-1:0]        idx_in;
  logic                    mapped;
  logic [NUM_SLAVES-1:0]   req_hot;
  logic                    ack_sel, resp_sel;
  logic [DATA_W-1:0]       rdata_sel;
  logic                    capture;
  logic [NUM_SLAVES-1:0]   s_req_n;
  logic                    m_ack_n, m_resp_n, m_err_n;
  logic [DATA_W-1:0]       m_rdata_n;
  logic                    cnt_load, cnt_en, expire;

  assign idx_in    = m_addr[ADDR_W-1 -: SEL_W];
  assign mapped    = ({1'b0, idx_in} < NS_V);
  assign dbg_state = state;

  // Decode of the incoming index and mux of the latched slave's channel.
  always_comb begin
    req_hot   = '0;
    ack_sel   = 1'b0;
    resp_sel  = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_in == SEL_W'(i)) req_hot[i] = 1'b1;
      if (idx_q == SEL_W'(i)) begin
        ack_sel   = s_ack[i];
        resp_sel  = s_resp[i];
        rdata_sel = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    s_req_n   = s_req;
    m_ack_n   = 1'b0;
    m_resp_n  = 1'b0;
    m_err_n   = 1'b0;
    m_rdata_n = m_rdata;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_req) begin
          capture = 1'b1;
          if (mapped) begin
            s_req_n  = req_hot;
            cnt_load = 1'b1;
            state_n  = ACK_WAIT;
          end else begin
            m_ack_n = 1'b1;
            m_err_n = 1'b1;
            if (!m_cmd) begin
              m_resp_n  = 1'b1;
              m_rdata_n = ERR_WORD;
            end
            state_n = DONE;
          end
        end
      end
      ACK_WAIT: begin
        cnt_en = 1'b1;
        if (ack_sel) begin
          m_ack_n = 1'b1;
          if (s_cmd) begin
            s_req_n = '0;
            state_n = DONE;
          end else if (resp_sel) begin
            m_resp_n  = 1'b1;
            m_rdata_n = rdata_sel;
            s_req_n   = '0;
            state_n   = DONE;
          end else begin
            cnt_load = 1'b1;
            state_n  = RESP_WAIT;
          end
        end else if (expire) begin
          s_req_n = '0;
          m_ack_n = 1'b1;
          m_err_n = 1'b1;
          if (!s_cmd) begin
            m_resp_n  = 1'b1;
            m_rdata_n = ERR_WORD;
          end
          state_n = DONE;
        end
      end
      RESP_WAIT: begin
        cnt_en = 1'b1;
        if (resp_sel) begin
          m_resp_n  = 1'b1;
          m_rdata_n = rdata_sel;
          s_req_n   = '0;
          state_n   = DONE;
        end else if (expire) begin
          m_resp_n  = 1'b1;
          m_err_n   = 1'b1;
          m_rdata_n = ERR_WORD;
          s_req_n   = '0;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (!m_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      idx_q   <= '0;
      s_cmd   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_req   <= '0;
      m_ack   <= 1'b0;
      m_resp  <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      state   <= state_n;
      s_req   <= s_req_n;
      m_ack   <= m_ack_n;
      m_resp  <= m_resp_n;
      m_err   <= m_err_n;
      m_rdata <= m_rdata_n;
      if (capture) begin
        idx_q   <= idx_in;
        s_cmd   <= m_cmd;
        s_addr  <= m_addr[ADDR_W-SEL_W-1:0];
        s_wdata <= m_wdata;
      end
    end
  end

  bus_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .load   (cnt_load),
    .enable (cnt_en),
    .expire (expire)
  );

endmodule

// File: tb/tb_bus_router_n.sv
// Bench for bus_router_n with three slaves and an 8-cycle timeout.
// A bench-side slave model drives acks/responses; a monitor pops expected master pulses.
module tb_bus_router_n;
  import bus_router_pkg::*;

  localparam int          NS  = 3;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_req = 1'b0, m_cmd = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_ack, m_resp, m_err;
  logic [31:0] m_rdata;
  logic [NS-1:0] s_req;
  logic        s_cmd;
  logic [29:0] s_addr;
  logic [31:0] s_wdata;
  logic [NS-1:0] s_ack = '0, s_resp = '0;
  logic [NS*32-1:0] s_rdata = '0;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  logic [31:0] last_rdata = '0;

  bus_router_n #(
    .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .ERR_DATA(ERR)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected master pulse {ack, resp, err, rdata}; rdata holds unless a response carries new data.
  function automatic void push_exp(input logic ack, input logic resp, input logic err,
                                   input logic [31:0] rd);
    if (resp) last_rdata = rd;
    exp_q.push_back({ack, resp, err, last_rdata});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_ack || m_resp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got ack=%b resp=%b err=%b expected no pulse",
                   m_ack, m_resp, m_err);
        end else begin
          mon_e = exp_q.pop_front();
          chk("master_pulse", {29'b0, m_ack, m_resp, m_err, m_rdata}, {29'b0, mon_e});
        end
      end else begin
        chk("idle_err", 64'(m_err), 64'd0);
      end
    end
  end

  task automatic do_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] data, input int ack_dly, input int resp_dly,
                        input bit same, input bit stray, input bit late);
    logic [1:0]    idx;
    bit            mapped;
    logic [NS-1:0] hot, oth;
    int            n;
    idx    = addr[31:30];
    mapped = int'(idx) < NS;
    hot    = mapped ? (NS'(1) << idx) : '0;
    oth    = NS'(1) << ((int'(idx) + 2) % NS);

    // Outcome of each phase: slave event inside the window, otherwise timeout.
    if (!mapped)            push_exp(1'b1, !cmd, 1'b1, ERR);
    else if (ack_dly >= TO) push_exp(1'b1, !cmd, 1'b1, ERR);
    else if (cmd)           push_exp(1'b1, 1'b0, 1'b0, '0);
    else if (same)          push_exp(1'b1, 1'b1, 1'b0, data);
    else begin
      push_exp(1'b1, 1'b0, 1'b0, '0);
      if (resp_dly >= TO) push_exp(1'b0, 1'b1, 1'b1, ERR);
      else                push_exp(1'b0, 1'b1, 1'b0, data);
    end

    @(negedge clk);
    m_req = 1'b1; m_cmd = cmd; m_addr = addr; m_wdata = wdata;
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
    if (mapped) s_rdata[int'(idx)*32 +: 32] = data;
    @(negedge clk);
    chk("s_req_rise", 64'(s_req), 64'(hot));
    if (!mapped) begin
      chk("dec_err_ack", 64'({m_ack, m_err}), 64'(2'b11));
    end else begin
      chk("s_addr", 64'(s_addr), 64'(addr[29:0]));
      chk("s_wdata", 64'(s_wdata), 64'(wdata));
      chk("s_cmd", 64'(s_cmd), 64'(cmd));
      n = (ack_dly < TO) ? ack_dly : TO;
      for (int k = 0; k < n; k++) begin
        chk("s_req_hold_ack", 64'(s_req), 64'(hot));
        chk("s_addr_hold", 64'(s_addr), 64'(addr[29:0]));
        if (stray) begin s_ack = oth; s_resp = oth; end
        @(negedge clk);
        s_ack = '0; s_resp = '0;
      end
      if (ack_dly >= TO) begin
        chk("ack_to_sreq", 64'(s_req), 64'd0);
        chk("ack_to_pulse", 64'({m_ack, m_resp, m_err}), 64'({1'b1, !cmd, 1'b1}));
      end else begin
        s_ack = hot;
        if (!cmd && same) s_resp = hot;
        @(negedge clk);
        s_ack = '0; s_resp = '0;
        chk("ack_pulse", 64'(m_ack), 64'd1);
        if (cmd || same) begin
          chk("s_req_drop", 64'(s_req), 64'd0);
        end else begin
          n = (resp_dly < TO) ? resp_dly : TO;
          for (int k = 0; k < n; k++) begin
            chk("s_req_hold_resp", 64'(s_req), 64'(hot));
            if (stray) s_resp = oth;
            @(negedge clk);
            s_resp = '0;
          end
          if (resp_dly >= TO) begin
            chk("resp_to_sreq", 64'(s_req), 64'd0);
            chk("resp_to_pulse", 64'({m_ack, m_resp, m_err}), 64'(3'b011));
          end else begin
            chk("s_req_before_resp", 64'(s_req), 64'(hot));
            s_resp = hot;
            @(negedge clk);
            s_resp = '0;
            chk("resp_sreq", 64'(s_req), 64'd0);
            chk("resp_pulse", 64'({m_ack, m_resp, m_err}), 64'(3'b010));
          end
        end
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending pulses expected 0", exp_q.size());
      exp_q.delete();
    end
    for (int k = 0; k < 2; k++) begin
      if (late && mapped) begin s_ack = hot; s_resp = hot; end
      @(negedge clk);
      s_ack = '0; s_resp = '0;
      chk("done_no_req", 64'(s_req), 64'd0);
    end
    m_req = 1'b0;
    @(negedge clk);
    chk("back_idle", 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_m_out", 64'({m_ack, m_resp, m_err}), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    do_txn(1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0, 1, 0, 0, 0, 0);
    do_txn(1'b0, 32'h4000_0004, 32'h0, 32'hCAFE_0001, 0, 2, 0, 0, 0);
    do_txn(1'b0, 32'h8000_0100, 32'h0, 32'h5A5A_0003, 2, 0, 1, 0, 0);
    do_txn(1'b0, 32'hC000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    do_txn(1'b1, 32'hC000_0004, 32'hFFFF_0000, 32'h0, 0, 0, 0, 0, 0);
    do_txn(1'b0, 32'h0000_0040, 32'h0, 32'h0, 20, 0, 0, 1, 0);
    do_txn(1'b0, 32'h4000_0080, 32'h0, 32'h7777_1234, TO - 1, TO - 1, 0, 1, 0);
    do_txn(1'b0, 32'h0000_0008, 32'h0, 32'h1111_2222, 0, TO + 1, 0, 0, 1);
    do_txn(1'b1, 32'h4000_000C, 32'hABCD_EF01, 32'h0, TO, 0, 0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom_range(0, 1)),
             {2'($urandom_range(0, 3)), 30'($urandom)},
             $urandom, $urandom,
             $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while a read waits for its response: nothing may follow it.
    push_exp(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    m_req = 1'b1; m_cmd = 1'b0; m_addr = 32'h4000_0020; m_wdata = 32'h9999_8888;
    @(negedge clk);
    s_ack = 3'b010;
    @(negedge clk);
    s_ack = '0;
    @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'(RESP_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_req", 64'(s_req), 64'd0);
    chk("arst_m_out", 64'({m_ack, m_resp, m_err}), 64'd0);
    chk("arst_m_rdata", 64'(m_rdata), 64'd0);
    chk("arst_shared", 64'({s_cmd, s_addr}), 64'd0);
    chk("arst_wdata", 64'(s_wdata), 64'd0);
    chk("arst_state", 64'(dbg_state), 64'(IDLE));
    m_req = 1'b0;
    exp_q.delete();
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_resp = 3'b010;
    @(negedge clk);
    s_resp = '0;
    chk("late_resp_idle", 64'(s_req), 64'd0);
    do_txn(1'b1, 32'h8000_0040, 32'h0BAD_F00D, 32'h0, 1, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
